// File: rtl/shake_sponge_ctrl_if.sv
// Bundle of the accumulator, permutation-core and squeeze buses for the SHAKE256 sponge sequencer.
// master = sequencer view (drives pulses, state and squeeze output); slave = surrounding datapath view.
// Widths follow the sponge parameters so one instance can serve the sequencer and its environment.
interface shake_sponge_ctrl_if #(
    parameter int RATE_BITS  = 1088,
    parameter int STATE_BITS = 1600,
    parameter int OUT_CNT_W  = 8
) ();
    logic                  start;
    logic [OUT_CNT_W-1:0]  out_blocks;
    logic                  acc_clear;
    logic                  accum_start;
    logic                  accum_done;
    logic [RATE_BITS-1:0]  block_in;
    logic                  last_block;
    logic                  perm_start;
    logic [STATE_BITS-1:0] perm_state_out;
    logic                  perm_done;
    logic [STATE_BITS-1:0] perm_state_in;
    logic                  squeeze_valid;
    logic [RATE_BITS-1:0]  squeeze_data;
    logic                  squeeze_ready;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, out_blocks, accum_done, block_in, last_block,
               perm_done, perm_state_in, squeeze_ready,
        output acc_clear, accum_start, perm_start, perm_state_out,
               squeeze_valid, squeeze_data, busy, done
    );

    modport slave (
        output start, out_blocks, accum_done, block_in, last_block,
               perm_done, perm_state_in, squeeze_ready,
        input  acc_clear, accum_start, perm_start, perm_state_out,
               squeeze_valid, squeeze_data, busy, done
    );
endinterface

// File: rtl/shake_sponge_ctrl.sv
// Sponge sequencer: absorbs accumulator blocks into the Keccak state, runs the core, squeezes rate blocks.
// Latency: start -> acc_clear 1 cycle; perm_done -> squeeze_valid 1 cycle; last handshake -> done 1 cycle.
// Backpressure: squeeze_valid/data hold until squeeze_ready; stalled accumulator or core holds the FSM, no timeout.
module shake_sponge_ctrl #(
    parameter int RATE_BITS  = 1088,
    parameter int STATE_BITS = 1600,
    parameter int OUT_CNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    shake_sponge_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, CLEAR, ARM, WAIT_BLK, PERM_GO, PERM_WAIT, SQUEEZE, FIN
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [STATE_BITS-1:0]   sponge_q;
    logic [OUT_CNT_W-1:0]    remaining_q;
    logic [OUT_CNT_W-1:0]    remaining_dec;
    logic                    squeeze_phase_q;
    logic                    last_q;

    assign remaining_dec = remaining_q - OUT_CNT_W'(1);

    // FSM state register; reset aborts whatever is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; every wait state simply holds until its input event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.start) state_d = CLEAR;
            CLEAR:     state_d = ARM;
            ARM:       state_d = WAIT_BLK;
            WAIT_BLK:  if (bus.accum_done) state_d = PERM_GO;
            PERM_GO:   state_d = PERM_WAIT;
            PERM_WAIT: begin
                if (bus.perm_done) begin
                    // Last absorb permutation and every squeeze permutation both lead to output.
                    if (squeeze_phase_q || last_q) state_d = SQUEEZE;
                    else                           state_d = CLEAR;
                end
            end
            SQUEEZE: begin
                if (bus.squeeze_ready) begin
                    if (remaining_dec == '0) state_d = FIN;
                    else                     state_d = PERM_GO;
                end
            end
            FIN:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Sponge datapath: rate-only XOR on absorb, whole-state load from the core, squeeze countdown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sponge_q        <= '0;
            remaining_q     <= '0;
            squeeze_phase_q <= 1'b0;
            last_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sponge_q        <= '0;
                        remaining_q     <= (bus.out_blocks == '0) ? OUT_CNT_W'(1) : bus.out_blocks;
                        squeeze_phase_q <= 1'b0;
                        last_q          <= 1'b0;
                    end
                end
                WAIT_BLK: begin
                    if (bus.accum_done) begin
                        sponge_q[RATE_BITS-1:0] <= sponge_q[RATE_BITS-1:0] ^ bus.block_in;
                        last_q                  <= bus.last_block;
                    end
                end
                PERM_WAIT: begin
                    if (bus.perm_done) begin
                        sponge_q <= bus.perm_state_in;
                        if (last_q) squeeze_phase_q <= 1'b1;
                    end
                end
                SQUEEZE: begin
                    if (bus.squeeze_ready) remaining_q <= remaining_dec;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the registered state; state buses follow the sponge register.
    assign bus.acc_clear      = (state_q == CLEAR);
    assign bus.accum_start    = (state_q == ARM);
    assign bus.perm_start     = (state_q == PERM_GO);
    assign bus.squeeze_valid  = (state_q == SQUEEZE);
    assign bus.done           = (state_q == FIN);
    assign bus.busy           = (state_q != IDLE);
    assign bus.perm_state_out = sponge_q;
    assign bus.squeeze_data   = sponge_q[RATE_BITS-1:0];
endmodule

// File: tb/tb_shake_sponge_ctrl.sv
// Bench for the sponge sequencer: accumulator, core and consumer models plus a sponge-level reference.
// Expected outputs are derived per cycle from observed events and the absorb/squeeze rules.
// Randomised block data, latencies and ready stalls.
module tb_shake_sponge_ctrl;
    localparam int R = 1088;
    localparam int S = 1600;
    localparam int W = 8;
    localparam logic [S-1:0] KMIX = {25{64'h9E3779B97F4A7C15}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    shake_sponge_ctrl_if #(.RATE_BITS(R), .STATE_BITS(S), .OUT_CNT_W(W)) ifc ();
    shake_sponge_ctrl #(.RATE_BITS(R), .STATE_BITS(S), .OUT_CNT_W(W)) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    int checks = 0;
    int errors = 0;

    // run configuration and reference model
    int cfg_nblk, cfg_nout, cfg_outb, cfg_stall, cfg_lat;
    bit cfg_ident, cfg_stray;
    logic [R-1:0] blk_q[$];
    logic [S-1:0] exp_pin[$];
    logic [R-1:0] exp_sq[$];
    int bidx;

    // shared observation state
    bit acc_rise, pd_real;
    int n_clr, n_pst, n_done, done_cnt;
    logic [R-1:0] sq_seen;
    int acnt, pcnt, scnt, sq_wait, cur_stall;
    logic [S-1:0] pcap;

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%0b exp=%0b t=%0t", n, a, e, $time);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", n, a, e, $time);
        end
    endtask

    task automatic chkw(input string n, input logic [S-1:0] a, input logic [S-1:0] e);
        int wd;
        checks++;
        if (a !== e) begin
            errors++;
            wd = 0;
            for (int i = S/32 - 1; i >= 0; i--) if (a[i*32 +: 32] !== e[i*32 +: 32]) wd = i;
            $display("FAIL %s word%0d act=%h exp=%h t=%0t", n, wd, a[wd*32 +: 32], e[wd*32 +: 32], $time);
        end
    endtask

    function automatic logic [R-1:0] rand_rate();
        logic [R-1:0] v;
        for (int i = 0; i < R/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [S-1:0] rand_state();
        logic [S-1:0] v;
        for (int i = 0; i < S/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Stand-in permutation: identity, or rotate-left-7 XOR a fixed pattern.
    function automatic logic [S-1:0] core_fn(input logic [S-1:0] s, input bit ident);
        if (ident) return s;
        return {s[S-8:0], s[S-1:S-7]} ^ KMIX;
    endfunction

    // Sponge reference: absorb rate-only XORs, then one rate block per output with a permutation in between.
    task automatic prep(input int nblk, input int outb, input bit ident, input int stall,
                        input int lat, input bit stray, input bit ones);
        logic [S-1:0] st;
        logic [R-1:0] b;
        cfg_nblk = nblk; cfg_outb = outb; cfg_nout = (outb == 0) ? 1 : outb;
        cfg_ident = ident; cfg_stall = stall; cfg_lat = lat; cfg_stray = stray;
        blk_q.delete(); exp_pin.delete(); exp_sq.delete(); bidx = 0;
        st = '0;
        for (int i = 0; i < nblk; i++) begin
            b = ones ? {R{1'b1}} : rand_rate();
            blk_q.push_back(b);
            st[R-1:0] = st[R-1:0] ^ b;
            exp_pin.push_back(st);
            st = core_fn(st, ident);
        end
        for (int j = 0; j < cfg_nout; j++) begin
            exp_sq.push_back(st[R-1:0]);
            if (j < cfg_nout - 1) begin
                exp_pin.push_back(st);
                st = core_fn(st, ident);
            end
        end
    endtask

    task automatic pulse_start();
        n_clr = 0; n_pst = 0; n_done = 0;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.out_blocks = W'(cfg_outb);
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.out_blocks = W'($urandom);
    endtask

    task automatic go(input bit busy_start);
        int base, cyc;
        bit saw_arm;
        base = done_cnt; cyc = 0; saw_arm = 0;
        pulse_start();
        while (done_cnt == base && cyc < 20000) begin
            @(negedge clk);
            ifc.start = (busy_start && saw_arm);
            if (ifc.start) ifc.out_blocks = W'($urandom);
            saw_arm = ifc.accum_start;
            cyc++;
        end
        ifc.start = 1'b0;
        chk1("done_within_budget", done_cnt != base, 1'b1);
        repeat (2) @(negedge clk);
        chki("n_acc_clear", n_clr, cfg_nblk);
        chki("n_perm_start", n_pst, cfg_nblk + cfg_nout - 1);
        chki("n_done", n_done, 1);
        chki("perm_inputs_left", exp_pin.size(), 0);
        chki("squeeze_blocks_left", exp_sq.size(), 0);
    endtask

    // Accumulator model: done level some cycles after accum_start, cleared by acc_clear.
    initial begin
        ifc.accum_done = 1'b0; ifc.block_in = '0; ifc.last_block = 1'b0; acnt = 0;
        forever begin
            @(negedge clk);
            acc_rise = 1'b0;
            if (reset) begin
                acnt = 0;
                ifc.accum_done = 1'b0;
            end else begin
                if (ifc.perm_start) begin
                    ifc.block_in = rand_rate();
                    ifc.last_block = 1'($urandom % 2);
                end
                if (ifc.acc_clear) ifc.accum_done = 1'b0;
                if (ifc.accum_start) begin
                    acnt = $urandom_range(1, 4);
                end else if (acnt > 0) begin
                    acnt--;
                    if (acnt == 0) begin
                        ifc.accum_done = 1'b1;
                        ifc.block_in = (bidx < blk_q.size()) ? blk_q[bidx] : '0;
                        ifc.last_block = (bidx == cfg_nblk - 1);
                        bidx++;
                        acc_rise = 1'b1;
                    end
                end
            end
        end
    end

    // Permutation core model, with an optional stray done pulse while a block is awaited.
    initial begin
        ifc.perm_done = 1'b0; ifc.perm_state_in = '0; pcnt = 0; scnt = 0;
        forever begin
            @(negedge clk);
            pd_real = 1'b0;
            ifc.perm_done = 1'b0;
            ifc.perm_state_in = rand_state();
            if (reset) begin
                pcnt = 0; scnt = 0;
            end else begin
                if (ifc.perm_start) begin
                    pcap = ifc.perm_state_out;
                    pcnt = (cfg_lat > 0) ? cfg_lat : $urandom_range(1, 5);
                end else if (pcnt > 0) begin
                    pcnt--;
                    if (pcnt == 0) begin
                        ifc.perm_done = 1'b1;
                        ifc.perm_state_in = core_fn(pcap, cfg_ident);
                        pd_real = 1'b1;
                    end
                end
                if (cfg_stray && ifc.accum_start) begin
                    scnt = 1;
                end else if (scnt == 1) begin
                    scnt = 0;
                    ifc.perm_done = 1'b1;
                end
            end
        end
    end

    // Consumer model: stalls ready per block, random ready noise while nothing is offered.
    initial begin
        ifc.squeeze_ready = 1'b0; sq_wait = 0; cur_stall = 0;
        forever begin
            @(negedge clk);
            if (ifc.squeeze_valid) begin
                if (sq_wait == 0) cur_stall = (cfg_stall < 0) ? $urandom_range(0, 3) : cfg_stall;
                ifc.squeeze_ready = (sq_wait >= cur_stall);
                sq_wait++;
            end else begin
                sq_wait = 0;
                ifc.squeeze_ready = 1'($urandom % 2);
            end
        end
    end

    // Per-cycle compare against expectations derived from observed events.
    initial begin
        bit p_valid, p_clr, p_done, exp_busy;
        bit start_acc, hs, last_hs, pd;
        bit e_clr, e_arm, e_pst, e_sqv, e_done, e_busy;
        int pidx, sq_cnt;
        p_valid = 0; p_clr = 0; p_done = 0; exp_busy = 0; pidx = 0; sq_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                p_valid = 0; p_clr = 0; p_done = 0; exp_busy = 0;
            end else begin
                start_acc = ifc.start && !exp_busy;
                hs        = p_valid && ifc.squeeze_ready;
                last_hs   = hs && (sq_cnt + 1 == cfg_nout);
                pd        = ifc.perm_done && pd_real;
                if (start_acc) begin pidx = 0; sq_cnt = 0; end
                e_clr  = start_acc || (pd && pidx < cfg_nblk - 1);
                e_arm  = p_clr;
                e_pst  = acc_rise || (hs && !last_hs);
                e_sqv  = (pd && pidx >= cfg_nblk - 1) || (p_valid && !hs);
                e_done = last_hs;
                e_busy = (exp_busy && !p_done) || start_acc;
                chk1("acc_clear", ifc.acc_clear, e_clr);
                chk1("accum_start", ifc.accum_start, e_arm);
                chk1("perm_start", ifc.perm_start, e_pst);
                chk1("squeeze_valid", ifc.squeeze_valid, e_sqv);
                chk1("done", ifc.done, e_done);
                chk1("busy", ifc.busy, e_busy);
                if (hs) begin
                    if (exp_sq.size() > 0) void'(exp_sq.pop_front());
                    sq_cnt++;
                end
                if (pd) pidx++;
                if (ifc.perm_start) begin
                    n_pst++;
                    if (exp_pin.size() == 0) chki("perm_input_available", 0, 1);
                    else chkw("perm_state_out", ifc.perm_state_out, exp_pin.pop_front());
                end
                if (ifc.squeeze_valid) begin
                    sq_seen = ifc.squeeze_data;
                    if (exp_sq.size() == 0) chki("squeeze_block_available", 0, 1);
                    else chkw("squeeze_data", {{(S-R){1'b0}}, ifc.squeeze_data}, {{(S-R){1'b0}}, exp_sq[0]});
                end
                if (ifc.acc_clear) n_clr++;
                if (ifc.done) begin n_done++; done_cnt++; end
                p_valid = e_sqv; p_clr = e_clr; p_done = e_done; exp_busy = e_busy;
            end
        end
    end

    initial begin
        logic [S-1:0] tmp;
        int k;
        ifc.start = 1'b0; ifc.out_blocks = '0;
        cfg_nblk = 1; cfg_nout = 1; cfg_outb = 1; cfg_stall = 0; cfg_lat = 1;
        cfg_ident = 1; cfg_stray = 0; bidx = 0; done_cnt = 0;
        n_clr = 0; n_pst = 0; n_done = 0; sq_seen = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk1("rst_busy", ifc.busy, 1'b0);
        chk1("rst_acc_clear", ifc.acc_clear, 1'b0);
        chk1("rst_squeeze_valid", ifc.squeeze_valid, 1'b0);
        chk1("rst_done", ifc.done, 1'b0);
        chkw("rst_state", ifc.perm_state_out, '0);
        reset = 1'b0;

        // model pins: mixing zero gives the pattern; identity core leaves the absorbed block
        tmp = core_fn('0, 1'b0);
        chkw("model_mix_zero", tmp, {25{64'h9E3779B97F4A7C15}});

        // single all-ones block, identity core 5 cycles
        prep(1, 1, 1'b1, 0, 5, 1'b0, 1'b1);
        chkw("model_ones", {{(S-R){1'b0}}, exp_sq[0]}, {{(S-R){1'b0}}, {R{1'b1}}});
        go(1'b0);
        chkw("t1_squeeze_ones", {{(S-R){1'b0}}, sq_seen}, {{(S-R){1'b0}}, {R{1'b1}}});

        // three blocks, identity core: rate is XOR of blocks, capacity stays zero
        prep(3, 1, 1'b1, 0, 0, 1'b0, 1'b0);
        go(1'b0);
        tmp = {{(S-R){1'b0}}, blk_q[0] ^ blk_q[1] ^ blk_q[2]};
        chkw("t2_final_state", ifc.perm_state_out, tmp);

        // three outputs with 4-cycle ready stalls
        prep(2, 3, 1'b0, 4, 0, 1'b0, 1'b0);
        go(1'b0);

        // out_blocks=0 behaves as 1; start while busy ignored
        prep(1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        go(1'b1);

        // stray perm_done while awaiting a block, held accum_done during the permutation
        prep(2, 2, 1'b0, -1, 0, 1'b1, 1'b0);
        go(1'b0);

        // reset while waiting for the core
        prep(2, 1, 1'b0, 0, 4, 1'b0, 1'b0);
        pulse_start();
        k = 0;
        while (!ifc.perm_start && k < 200) begin @(negedge clk); k++; end
        chk1("reach_perm_go", ifc.perm_start, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("mid_rst_busy", ifc.busy, 1'b0);
        chk1("mid_rst_perm_start", ifc.perm_start, 1'b0);
        chk1("mid_rst_accum_start", ifc.accum_start, 1'b0);
        chk1("mid_rst_squeeze_valid", ifc.squeeze_valid, 1'b0);
        chk1("mid_rst_done", ifc.done, 1'b0);
        chkw("mid_rst_state", ifc.perm_state_out, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prep(2, 2, 1'b0, -1, 0, 1'b0, 1'b0);
        go(1'b0);

        // randomised runs
        for (int r = 0; r < 6; r++) begin
            prep($urandom_range(1, 4), $urandom_range(0, 5), 1'($urandom % 2), -1, 0, 1'($urandom % 2), 1'b0);
            go(1'($urandom % 2));
        end

        // maximum count runs to completion without wrap
        prep(1, 255, 1'b0, 0, 1, 1'b0, 1'b0);
        go(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
